fp16_accum_seq: RTL and testbench
=================================

# fp16_accum_seq

Reduction sequencer that sits directly upstream of the FP16 adder stage and feeds it. It accepts a vector of FP16 elements over a valid/ready stream and issues one addition per element to the adder: accumulator plus element. It captures each adder result when the adder signals completion. When the vector is exhausted, it presents the final FP16 sum with a one-cycle valid pulse.

## Interface
- LEN_W, default 8 — width of the vector-length input and of the element counter; maximum vector length is 2^LEN_W-1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  begin a new reduction. Sampled only in IDLE.
- len  input  LEN_W  number of elements in the vector. Latched when start is accepted. 0 is legal.
- in_data  input  16  FP16 element.
- in_valid  input  1  in_data valid.
- in_ready  output  1  sequencer can accept an element.
- add_data1  output  16  adder operand 1, the accumulator.
- add_data2  output  16  adder operand 2, the current element.
- add_valid  output  1  adder data_valid, a single-cycle pulse.
- add_result  input  16  adder result.
- add_complete  input  1  adder completion pulse.
- sum  output  16  final FP16 sum. Held until the next accepted start.
- sum_valid  output  1  one-cycle pulse when sum is final.
- busy  output  1  high in every state except IDLE.

## Operation
Registers:
- acc[15:0], elem[15:0]
- cnt[LEN_W-1:0], len_r[LEN_W-1:0]
- 3-bit state

States and transitions:
- IDLE: busy=0, in_ready=0.
  - On start: len_r<=len, cnt<=0, acc<=16'h0000.
  - If len==0, go to DONE; otherwise go to FETCH.
- FETCH: in_ready=1.
  - On in_valid&&in_ready: elem<=in_data, go to ISSUE.
- ISSUE: add_valid=1 for exactly this cycle, then go to WAIT.
- WAIT: add_valid=0.
  - On add_complete: acc<=add_result, cnt<=cnt+1.
  - If cnt+1==len_r, go to DONE; otherwise go to FETCH.
- DONE: sum_valid=1 for this cycle, then go to IDLE.

Output rules:
- add_data1=acc and add_data2=elem in all states. Both are stable from ISSUE through the completion cycle.
- sum=acc.

Boundary conditions and fixed behaviour:
- The accumulator starts at +0. The adder returns the other operand unchanged when one operand is zero, so the first addition yields the first element exactly.
- start while busy=1 is ignored. There is no queueing.
- add_complete outside WAIT is ignored. acc does not change.
- in_valid outside FETCH is not consumed. in_ready=0 there.
- Adder saturation (result exponent capped at 5'b11110, mantissa all ones) propagates unchanged into acc. The sequencer adds no overflow handling of its own.
- Reset mid-operation: immediate return to IDLE. Every register and output clears.

## Timing
- Reset values: in_ready=0, add_valid=0, add_data1=0, add_data2=0, sum=0x0000, sum_valid=0, busy=0, state=IDLE, acc=0, elem=0, cnt=0, len_r=0.
- Adder contract:
  - The adder registers its operands on the cycle add_valid=1.
  - add_complete rises on the next cycle.
  - add_result is valid while add_complete=1.
  - add_valid is never held for two consecutive cycles.
- With in_valid held high and start accepted in cycle 0:
  - Element k (1-based) is accepted in cycle 3k-2.
  - add_valid is high in cycle 3k-1.
  - The result is captured in cycle 3k.
- Throughput is 3 cycles per element.
- sum_valid is high in cycle 3·len+1.
- For len=0, sum_valid is high in cycle 1.
- busy falls in the cycle after sum_valid.
- Input stalls (in_valid=0 during FETCH) extend FETCH one cycle per stall cycle. No other state changes.

## Test plan
- len=3, elements 0x3C00, 0x4000, 0x4200, in_valid held high -> sum=0x4600 with sum_valid in cycle 10; exactly 3 add_valid pulses.
- len=2, elements 0x3C00, 0xBC00 -> sum=0x0000 in cycle 7.
- len=0 -> sum_valid in cycle 1, sum=0x0000, no add_valid pulse, in_ready never high.
- len=2, elements 0x7BFF, 0x7BFF -> sum=0x7BFF (saturated) in cycle 7.
- len=4, all elements 0x3C00, in_valid with 2-cycle gaps between elements, plus a start pulse while busy -> sum=0x4400, stalls lengthen FETCH only, and the second start is ignored.
- Reset while in WAIT of a len=3 run -> all outputs return to their reset values asynchronously. A fresh len=1 run with 0x4000 then gives sum=0x4000 in cycle 4.

Source files
------------

// File: rtl/fp16_accum_seq.sv
// rtl/fp16_accum_seq.sv - FP16 reduction sequencer feeding an external FP16 adder
// One element per adder round trip: FETCH accepts, ISSUE pulses the adder, WAIT captures the result.
module fp16_accum_seq #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [15:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [15:0]      add_data1,
   output logic [15:0]      add_data2,
   output logic             add_valid,
   input  logic [15:0]      add_result,
   input  logic             add_complete,
   output logic [15:0]      sum,
   output logic             sum_valid,
   output logic             busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [15:0]      acc;
   logic [15:0]      elem;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] len_r;
   logic [LEN_W-1:0] cnt_inc;

   assign cnt_inc   = cnt + 1'b1;
   assign add_data1 = acc;
   assign add_data2 = elem;
   assign sum       = acc;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (len == '0) ? DONE : FETCH;
         FETCH:   if (in_valid) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (add_complete) state_nxt = (cnt_inc == len_r) ? DONE : FETCH;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they are registered yet line up with the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         acc       <= '0;
         elem      <= '0;
         cnt       <= '0;
         len_r     <= '0;
         in_ready  <= 1'b0;
         add_valid <= 1'b0;
         sum_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == FETCH);
         add_valid <= (state_nxt == ISSUE);
         sum_valid <= (state_nxt == DONE);
         busy      <= (state_nxt != IDLE);
         case (state)
            IDLE: begin
               if (start) begin
                  len_r <= len;
                  cnt   <= '0;
                  acc   <= '0;
               end
            end
            FETCH: begin
               if (in_valid) elem <= in_data;
            end
            WAIT: begin
               if (add_complete) begin
                  acc <= add_result;
                  cnt <= cnt_inc;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_accum_seq.sv
// tb/tb_fp16_accum_seq.sv - directed bench for fp16_accum_seq with a table-driven adder responder
// Cycle 0 is the cycle start is sampled; all sampling and driving happens on the falling edge.
module tb_fp16_accum_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] add_data1;
   logic [15:0] add_data2;
   logic        add_valid;
   logic [15:0] add_result;
   logic        add_complete;
   logic [15:0] sum;
   logic        sum_valid;
   logic        busy;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] elems [4];

   int          sv_cyc;
   int          n_av;
   int          n_ir;
   logic [15:0] got_sum;

   always #5 clk = ~clk;

   fp16_accum_seq #(.LEN_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .len          (len),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .add_data1    (add_data1),
      .add_data2    (add_data2),
      .add_valid    (add_valid),
      .add_result   (add_result),
      .add_complete (add_complete),
      .sum          (sum),
      .sum_valid    (sum_valid),
      .busy         (busy)
   );

   // Hand-computed FP16 sums for every operand pair the directed runs produce.
   function automatic logic [15:0] fp_ref(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] key;
      key = {a, b};
      if (a == 16'h0000) return b;
      if (b == 16'h0000) return a;
      case (key)
         32'h3C00_4000: return 16'h4200;
         32'h4200_4200: return 16'h4600;
         32'h3C00_BC00: return 16'h0000;
         32'h7BFF_7BFF: return 16'h7BFF;
         32'h3C00_3C00: return 16'h4000;
         32'h4000_3C00: return 16'h4200;
         32'h4200_3C00: return 16'h4400;
         default:       return 16'hDEAD;
      endcase
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         add_complete <= 1'b0;
         add_result   <= 16'h0000;
      end else begin
         add_complete <= add_valid;
         if (add_valid) add_result <= fp_ref(add_data1, add_data2);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // gap: in_valid held low for this many cycles before each element; busy_cyc: cycle to pulse a stray start.
   task automatic run(input int n, input int gap, input int busy_cyc,
                      output int svc, output int av, output int ir, output logic [15:0] s);
      int idx = 0;
      int g;
      int cyc;
      bit acc_prev = 0;
      g   = gap;
      svc = -1;
      av  = 0;
      ir  = 0;
      s   = 16'hXXXX;
      @(negedge clk);
      start = 1'b1;
      len   = n[7:0];
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (cyc < 200) begin
         if (acc_prev) begin
            idx++;
            g = gap;
         end
         in_data  = elems[(idx < 4) ? idx : 3];
         in_valid = (g == 0);
         if (g > 0) g--;
         start = (cyc == busy_cyc);
         if (cyc == busy_cyc) len = 8'd1;
         if (add_valid) av++;
         if (in_ready) ir++;
         if (sum_valid) begin
            svc = cyc;
            s   = sum;
            break;
         end
         acc_prev = in_ready && in_valid;
         @(negedge clk);
         cyc++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      len      = 8'd0;
      in_data  = 16'h0000;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
      chk("rst_add_valid", {31'd0, add_valid}, 32'd0);
      chk("rst_add_data",  {add_data1, add_data2}, 32'd0);
      chk("rst_sum",       {16'd0, sum},       32'd0);
      chk("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      rst = 1'b1;
      @(negedge clk);

      elems = '{16'h3C00, 16'h4000, 16'h4200, 16'h0000};
      run(3, 0, -1, sv_cyc, n_av, n_ir, got_sum);
      chk("len3_cycle", sv_cyc, 32'd10);
      chk("len3_sum",   {16'd0, got_sum}, 32'h4600);
      chk("len3_addv",  n_av, 32'd3);
      chk("len3_ready", n_ir, 32'd3);
      @(negedge clk);
      chk("len3_busy_low",  {31'd0, busy}, 32'd0);
      chk("len3_sum_held",  {16'd0, sum}, 32'h4600);
      chk("len3_svalid_pulse", {31'd0, sum_valid}, 32'd0);

      elems = '{16'h3C00, 16'hBC00, 16'h0000, 16'h0000};
      run(2, 0, -1, sv_cyc, n_av, n_ir, got_sum);
      chk("cancel_cycle", sv_cyc, 32'd7);
      chk("cancel_sum",   {16'd0, got_sum}, 32'h0000);

      run(0, 0, -1, sv_cyc, n_av, n_ir, got_sum);
      chk("len0_cycle", sv_cyc, 32'd1);
      chk("len0_sum",   {16'd0, got_sum}, 32'h0000);
      chk("len0_addv",  n_av, 32'd0);
      chk("len0_ready", n_ir, 32'd0);

      elems = '{16'h7BFF, 16'h7BFF, 16'h0000, 16'h0000};
      run(2, 0, -1, sv_cyc, n_av, n_ir, got_sum);
      chk("sat_cycle", sv_cyc, 32'd7);
      chk("sat_sum",   {16'd0, got_sum}, 32'h7BFF);

      // Four idle cycles before each element: two fall in ISSUE/WAIT, the rest stall FETCH.
      elems = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
      run(4, 4, 6, sv_cyc, n_av, n_ir, got_sum);
      chk("stall_cycle", sv_cyc, 32'd23);
      chk("stall_sum",   {16'd0, got_sum}, 32'h4400);
      chk("stall_addv",  n_av, 32'd4);
      chk("stall_ready", n_ir, 32'd14);
      @(negedge clk);
      chk("stall_no_restart", {31'd0, busy}, 32'd0);

      elems = '{16'h3C00, 16'h4000, 16'h4200, 16'h0000};
      @(negedge clk);
      start = 1'b1;
      len   = 8'd3;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h3C00;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_issue", {31'd0, add_valid}, 32'd1);
      @(negedge clk);
      chk("mid_wait_busy", {31'd0, busy}, 32'd1);
      chk("mid_wait_cmpl", {31'd0, add_complete}, 32'd1);
      rst = 1'b0;
      #1;
      chk("arst_busy",   {31'd0, busy},      32'd0);
      chk("arst_ready",  {31'd0, in_ready},  32'd0);
      chk("arst_addv",   {31'd0, add_valid}, 32'd0);
      chk("arst_data",   {add_data1, add_data2}, 32'd0);
      chk("arst_sum",    {15'd0, sum_valid, sum}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      elems = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
      run(1, 0, -1, sv_cyc, n_av, n_ir, got_sum);
      chk("fresh_cycle", sv_cyc, 32'd4);
      chk("fresh_sum",   {16'd0, got_sum}, 32'h4000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
